// File: rtl/fams_glyph_pkg.sv
// rtl/fams_glyph_pkg.sv - shared constants and FSM state type for the glyph scanner
package fams_glyph_pkg;

  localparam int   GLYPH_W = 8;
  localparam int   GLYPH_H = 16;
  localparam int   N_GLYPH = 10;
  localparam int   ADDR_W  = 7;
  localparam logic BLANK   = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } scan_state_e;

endpackage

// File: rtl/glyph_skid.sv
// rtl/glyph_skid.sv - one-entry skid buffer holding the ROM bit in flight when the consumer stalls
module glyph_skid (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic stall_i,
  input  logic valid_i,
  input  logic data_i,
  output logic valid_o,
  output logic data_o
);

  logic valid_q, valid_d;
  logic data_q, data_d;

  // Capture only on the first stalled edge; drain on any edge the pipeline advances.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (stall_i) begin
      if (!valid_q && valid_i) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/glyph_scan_ctrl.sv
// rtl/glyph_scan_ctrl.sv - scans one glyph ROM in raster order and streams its pixels with consumer stall
module glyph_scan_ctrl
  import fams_glyph_pkg::*;
#(
  parameter int GLYPH_W = fams_glyph_pkg::GLYPH_W,
  parameter int GLYPH_H = fams_glyph_pkg::GLYPH_H,
  parameter int N_GLYPH = fams_glyph_pkg::N_GLYPH
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          digit,
  input  logic                hold,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [N_GLYPH-1:0]  rom_q,
  output logic                pix,
  output logic                pix_valid,
  output logic [3:0]          pix_row,
  output logic [2:0]          pix_col,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GLYPH_W * GLYPH_H - 1);
  localparam logic [3:0]        LAST_ROW  = 4'(GLYPH_H - 1);
  localparam logic [2:0]        LAST_COL  = 3'(GLYPH_W - 1);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rq_v_q, rq_v_d;
  logic [3:0]        digit_q, digit_d;
  logic              dig_ok_q, dig_ok_d;
  logic              pix_q, pix_d;
  logic              pv_q, pv_d;
  logic [3:0]        row_q, row_d;
  logic [2:0]        col_q, col_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic stall;
  logic rom_bit;
  logic skid_v, skid_bit;
  logic src_v, src_bit;
  logic last_out;

  assign stall    = hold & pv_q;
  assign rom_bit  = dig_ok_q ? rom_q[digit_q] : BLANK;
  assign src_v    = skid_v | rq_v_q;
  assign src_bit  = skid_v ? skid_bit : rom_bit;
  assign last_out = pv_q & ~hold & (row_q == LAST_ROW) & (col_q == LAST_COL);

  glyph_skid u_skid (
    .clk_i   (clock),
    .rst_ni  (rst_n),
    .clear_i (state_q == IDLE),
    .stall_i (stall),
    .valid_i (rq_v_q),
    .data_i  (rom_bit),
    .valid_o (skid_v),
    .data_o  (skid_bit)
  );

  // rq_v_q marks that rom_q holds a pixel not yet moved into pix or the skid buffer.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    rq_v_d     = rq_v_q;
    digit_d    = digit_q;
    dig_ok_d   = dig_ok_q;
    pix_d      = pix_q;
    pv_d       = pv_q;
    row_d      = row_q;
    col_d      = col_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        rom_addr_d = '0;
        rq_v_d     = 1'b0;
        if (start) begin
          state_d  = PRIME;
          busy_d   = 1'b1;
          digit_d  = digit;
          dig_ok_d = int'(digit) < N_GLYPH;
        end
      end
      PRIME: begin
        rom_addr_d = rom_addr_q + ADDR_W'(1);
        rq_v_d     = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        rq_v_d = 1'b1;
        if (!stall) begin
          if (rom_addr_q == LAST_ADDR) begin
            state_d = FLUSH;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
          end
        end
      end
      FLUSH: begin
        rq_v_d = rq_v_q & skid_v;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == RUN || state_q == FLUSH) && !stall) begin
      if (src_v) begin
        pix_d = src_bit;
        pv_d  = 1'b1;
        if (pv_q) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 4'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end else begin
        pv_d = 1'b0;
      end
    end

    if (state_q == FLUSH && last_out) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      pv_d       = 1'b0;
      pix_d      = BLANK;
      row_d      = '0;
      col_d      = '0;
      rom_addr_d = '0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      rq_v_q     <= 1'b0;
      digit_q    <= '0;
      dig_ok_q   <= 1'b0;
      pix_q      <= 1'b0;
      pv_q       <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      rq_v_q     <= rq_v_d;
      digit_q    <= digit_d;
      dig_ok_q   <= dig_ok_d;
      pix_q      <= pix_d;
      pv_q       <= pv_d;
      row_q      <= row_d;
      col_q      <= col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pix       = pix_q;
  assign pix_valid = pv_q;
  assign pix_row   = row_q;
  assign pix_col   = col_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_glyph_scan_ctrl.sv
// tb/tb_glyph_scan_ctrl.sv - directed bench for glyph_scan_ctrl with a registered glyph ROM model
module tb_glyph_scan_ctrl;

  localparam int N_GLYPH = 10;

  logic               clock = 1'b0;
  logic               rst_n;
  logic               start;
  logic [3:0]         digit;
  logic               hold;
  logic [6:0]         rom_addr;
  logic [N_GLYPH-1:0] rom_q = '0;
  logic               pix;
  logic               pix_valid;
  logic [3:0]         pix_row;
  logic [2:0]         pix_col;
  logic               busy;
  logic               done;

  int n_chk  = 0;
  int n_fail = 0;

  glyph_scan_ctrl #(
    .GLYPH_W (8),
    .GLYPH_H (16),
    .N_GLYPH (N_GLYPH)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .digit     (digit),
    .hold      (hold),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .pix       (pix),
    .pix_valid (pix_valid),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Glyph 1 is the reference "1"; the others are arbitrary so a wrong select shows up.
  function automatic logic glyph_bit(input int g, input int a);
    if (g == 1)
      return (a >= 26 && a <= 29) || (a >= 35 && a <= 37) || (a >= 43 && a <= 45) ||
             (a >= 51 && a <= 53) || (a >= 59 && a <= 61) || (a >= 67 && a <= 69) ||
             (a >= 75 && a <= 77) || (a >= 83 && a <= 85) || (a >= 90 && a <= 94);
    return ((a * 5 + g * 3) % 7) < 3;
  endfunction

  function automatic logic exp_bit(input int dg, input int a);
    if (dg >= N_GLYPH) return 1'b0;
    return glyph_bit(dg, a);
  endfunction

  always @(posedge clock)
    for (int g = 0; g < N_GLYPH; g++) rom_q[g] <= glyph_bit(g, int'(rom_addr));

  int           acc_addr[$];
  logic         acc_pix[$];
  int           stab_err = 0;
  int           done_cnt = 0;
  logic         prev_hv  = 1'b0;
  logic         pix_s    = 1'b0;
  logic [3:0]   row_s    = '0;
  logic [2:0]   col_s    = '0;
  logic [127:0] addr_seen = '0;

  always @(negedge clock) begin
    if (!rst_n) begin
      prev_hv = 1'b0;
    end else begin
      if (prev_hv && (!pix_valid || pix !== pix_s || pix_row !== row_s || pix_col !== col_s))
        stab_err++;
      if (pix_valid && !hold) begin
        acc_addr.push_back(int'(pix_row) * 8 + int'(pix_col));
        acc_pix.push_back(pix);
      end
      prev_hv = pix_valid && hold;
      pix_s   = pix;
      row_s   = pix_row;
      col_s   = pix_col;
    end
    if (busy) addr_seen[rom_addr] = 1'b1;
    else      addr_seen = '0;
    if (done) done_cnt++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_scan(input int dg, input int hold_mode, input bit keep_start,
                          input int abort_at, input bit inject);
    int hpat[5] = '{1, 0, 1, 1, 0};
    int base, sbase, e, done_e, n, ord_err, pix_err, first;
    bit got_done, aborted, inj_s, inj_d;
    base     = acc_pix.size();
    sbase    = stab_err;
    got_done = 0;
    aborted  = 0;
    inj_s    = 0;
    inj_d    = 0;
    done_e   = -1;
    digit    = 4'(dg);
    start    = 1'b1;
    tick();
    if (!keep_start) start = 1'b0;
    check_eq("accept_busy", int'(busy), 1);
    check_eq("accept_addr", int'(rom_addr), 0);
    e = 0;
    while (!got_done && e < 1000) begin
      hold = (hold_mode == 1) ? (hpat[e % 5] != 0) : 1'b0;
      if (inject) begin
        if (!inj_s && acc_pix.size() - base == 40) begin
          start = 1'b1;
          inj_s = 1;
        end else begin
          start = 1'b0;
        end
        if (!inj_d && acc_pix.size() - base == 60) begin
          digit = 4'd3;
          inj_d = 1;
        end
      end
      tick();
      e++;
      if (e == 1) check_eq("prime_no_valid", int'(pix_valid), 0);
      if (e == 2) check_eq("first_valid_rc", int'({pix_valid, pix_row, pix_col}), 128);
      if (abort_at >= 0 && acc_pix.size() - base >= abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("abort_outs_zero",
                 int'({rom_addr, pix, pix_valid, pix_row, pix_col, busy, done}), 0);
        aborted = 1;
        break;
      end
      if (done) begin
        got_done = 1;
        done_e   = e;
      end
    end
    hold  = 1'b0;
    start = keep_start;
    if (aborted) return;
    check_eq("done_seen", int'(got_done), 1);
    check_eq("busy_low_at_done", int'(busy), 0);
    if (hold_mode == 0) check_eq("done_edge", done_e, 130);
    if (dg >= N_GLYPH) check_eq("addr_sweep", $countones(addr_seen), 128);
    n       = acc_pix.size() - base;
    ord_err = 0;
    pix_err = 0;
    first   = -1;
    for (int i = 0; i < n && i < 128; i++) begin
      if (acc_addr[base + i] != i) ord_err++;
      if (acc_pix[base + i] !== exp_bit(inject ? 1 : dg, i)) pix_err++;
      if (first < 0 && acc_pix[base + i] === 1'b1) first = acc_addr[base + i];
    end
    check_eq("accepted_count", n, 128);
    check_eq("order_errors", ord_err, 0);
    check_eq("pixel_errors", pix_err, 0);
    check_eq("hold_stability_errors", stab_err - sbase, 0);
    if (dg == 1) check_eq("first_one_addr", first, 26);
    if (!keep_start) begin
      tick();
      check_eq("done_one_cycle", int'(done), 0);
      check_eq("idle_outs", int'({busy, pix_valid, rom_addr}), 0);
    end
  endtask

  int d0;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    digit = 4'd0;
    hold  = 1'b0;
    repeat (3) tick();
    check_eq("reset_outs",
             int'({rom_addr, pix, pix_valid, pix_row, pix_col, busy, done}), 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_after_reset", int'({busy, pix_valid, rom_addr}), 0);

    run_scan(1, 0, 1'b0, -1, 1'b0);
    run_scan(1, 1, 1'b0, -1, 1'b0);
    run_scan(12, 0, 1'b0, -1, 1'b0);
    run_scan(1, 0, 1'b0, -1, 1'b1);

    d0 = done_cnt;
    run_scan(1, 0, 1'b0, 70, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_eq("abort_no_done", done_cnt - d0, 0);
    check_eq("abort_idle", int'({busy, pix_valid, rom_addr}), 0);
    run_scan(1, 0, 1'b0, -1, 1'b0);

    run_scan(1, 0, 1'b1, -1, 1'b0);
    run_scan(1, 0, 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/glyph_scan_ctrl.md
GLYPH_SCAN_CTRL -- requirements
Module: glyph_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset is permitted.
REQ-002 Parameter GLYPH_W SHALL default to 8 and set the glyph width in pixels (columns).
REQ-003 Parameter GLYPH_H SHALL default to 16 and set the glyph height in pixels (rows).
REQ-004 Parameter N_GLYPH SHALL default to 10 and set the number of glyph ROMs sharing the address bus.
REQ-005 The ports SHALL be as follows (name, direction, width, meaning):
- clock  in  1  rising-edge clock shared with the glyph ROMs.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to begin a scan; sampled only in IDLE.
- digit  in  4  glyph select; latched when start is accepted.
- hold  in  1  consumer stall; pix, pix_valid, pix_row and pix_col freeze while high.
- rom_addr  out  7  address shared by all glyph ROMs; address = row*GLYPH_W + col.
- rom_q  in  N_GLYPH  registered ROM outputs, one bit per glyph; data follows rom_addr by one clock.
- pix  out  1  pixel value.
- pix_valid  out  1  pix, pix_row and pix_col are valid.
- pix_row  out  4  row of the current pixel.
- pix_col  out  3  column of the current pixel.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at the end of a scan.

Function
REQ-006 The FSM SHALL have states IDLE, PRIME, RUN and FLUSH; the reset state is IDLE.
REQ-007 In IDLE, start=1 at edge k SHALL latch digit, set rom_addr=0, set busy=1 and move to PRIME.
REQ-008 PRIME SHALL last exactly one cycle, covering ROM read latency, then move to RUN.
REQ-009 In RUN, rom_addr SHALL increment by 1 on each edge where the pipeline advances; after address 127 is issued the FSM SHALL move to FLUSH.
REQ-010 With hold low throughout, the first pix_valid SHALL be high after edge k+2 and carry address 0; one pixel SHALL be emitted per cycle; address 127 SHALL be valid after edge k+129.
REQ-011 pix SHALL equal rom_q[digit_latched] for the address it represents; pix_row SHALL equal address/8 and pix_col SHALL equal address mod 8.
REQ-012 If the latched digit is ≥ N_GLYPH, the scan SHALL run normally with pix forced to 0 for all 128 pixels.
REQ-013 While hold=1 and pix_valid=1, the pixel outputs SHALL stay stable and rom_addr SHALL not advance.
REQ-014 A 1-entry skid buffer SHALL capture the in-flight rom_q bit on the first hold cycle, so that no pixel is dropped or duplicated in any hold pattern.
REQ-015 The pixel on which hold is asserted SHALL remain on the outputs.
REQ-016 A pixel is accepted on an edge where pix_valid=1 and hold=0.
REQ-017 Exactly 128 pixels SHALL be accepted per scan, in ascending address order.
REQ-018 done SHALL pulse for one cycle after the edge at which pixel 127 is accepted.
REQ-019 In that same cycle busy SHALL drop and the FSM SHALL return to IDLE.
REQ-020 start back-to-back with done SHALL be accepted in the next IDLE cycle.
REQ-021 start while busy SHALL be ignored.
REQ-022 Changes on digit after acceptance SHALL have no effect until the next scan.
REQ-023 rom_addr SHALL wrap-guard: it SHALL never exceed 127 and SHALL hold at 127 during FLUSH.
REQ-024 In IDLE, pix_valid SHALL be 0 and rom_addr SHALL be 0.

Reset
REQ-025 When rst_n=0, rom_addr, pix, pix_valid, pix_row, pix_col, busy and done SHALL all be 0, the skid buffer SHALL be empty and the FSM SHALL be in IDLE, asynchronously.
REQ-026 Reset asserted mid-scan SHALL abort the scan with no done pulse; after release, the next start SHALL begin a fresh scan at address 0.
REQ-027 Reset SHALL be released synchronously to clock by the upstream synchronizer; the block itself SHALL not contain a synchronizer.

Structure
REQ-028 Package fams_glyph_pkg SHALL hold GLYPH_W, GLYPH_H, ADDR_W (7), the FSM state enum, and the BLANK value (0) used for out-of-range digits.
REQ-029 The skid buffer SHALL be a sub-module named glyph_skid (1-bit data, valid/hold in, stable output).
REQ-030 The FSM, address counter and row/column derivation SHALL remain in glyph_scan_ctrl.

Verification
REQ-031 Scan with digit=1 and hold=0: accepted pixels that are 1 SHALL be exactly addresses 26-29, 35-37, 43-45, 51-53, 59-61, 67-69, 75-77, 83-85 and 90-94; the first pix=1 SHALL be at row 3, col 2; done SHALL pulse after edge k+130.
REQ-032 Scan with digit=1 and hold pattern 1,0,1,1,0 repeating: the accepted stream SHALL be identical to the hold-free stream (128 pixels, no drop or duplicate); pix SHALL be stable during every hold cycle.
REQ-033 Scan with digit=12: 128 accepted pixels SHALL all be 0, busy and done SHALL behave normally, and rom_addr SHALL still sweep 0..127.
REQ-034 start pulsed at pixel 40, and digit changed at pixel 60, during a digit=1 scan: there SHALL be no restart and the output SHALL be the unchanged digit-1 stream.
REQ-035 rst_n low at pixel 70: all outputs SHALL be 0 immediately with no done pulse; start after release SHALL give first pix_valid two edges later at address 0.
REQ-036 start held high continuously: scans SHALL run back-to-back, each 128 pixels, with one IDLE cycle between done and the next PRIME.
